// File: rtl/twofish_mode_ctrl.sv
// rtl/twofish_mode_ctrl.sv - ECB/CBC block-mode sequencer in front of a Twofish round core
`timescale 1ns/1ps

module twofish_mode_ctrl #(
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         iv_load,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         in_dir,
    input  logic         in_cbc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         error,
    output logic         core_Reset,
    output logic         core_Start,
    output logic         core_EnDe,
    output logic [127:0] core_block,
    output logic [127:0] core_key,
    input  logic [127:0] core_o,
    input  logic         core_busy
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_RUN,
        S_OUT,
        S_ERR
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [127:0]   r_chain;
    logic [127:0]   r_saved_in;
    logic [127:0]   r_core_block;
    logic [127:0]   r_core_key;
    logic [127:0]   r_out_block;
    logic           r_dir;
    logic           r_cbc;
    logic           r_error;
    logic [CW-1:0]  r_wait_cnt;

    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_start;
    logic           w_in_hs;
    logic           w_run_done;
    logic           w_timeout;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // iv_load wins over in_valid so the chain is never loaded mid-block.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_start     = 1'b0;
        w_in_hs     = 1'b0;
        w_run_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = ~iv_load;
                if (in_valid && !iv_load) begin
                    w_in_hs = 1'b1;
                    w_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_start = 1'b1;
                w_next  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (core_busy) begin
                    w_next = S_RUN;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_timeout = 1'b1;
                    w_next    = S_ERR;
                end
            end
            S_RUN: begin
                if (!core_busy) begin
                    w_run_done = 1'b1;
                    w_next     = S_OUT;
                end
            end
            S_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_ERR: begin
                w_next = S_ERR;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_chain      <= '0;
            r_saved_in   <= '0;
            r_core_block <= '0;
            r_core_key   <= '0;
            r_out_block  <= '0;
            r_dir        <= 1'b0;
            r_cbc        <= 1'b0;
            r_error      <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && iv_load) begin
                r_chain <= iv;
            end

            // Core inputs are latched once here and stay frozen until the next block.
            if (w_in_hs) begin
                r_dir        <= in_dir;
                r_cbc        <= in_cbc;
                r_core_key   <= key;
                r_saved_in   <= in_block;
                r_core_block <= (in_cbc && !in_dir) ? (in_block ^ r_chain) : in_block;
            end

            if (r_state == S_LOAD) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end

            if (w_timeout) begin
                r_error <= 1'b1;
            end

            if (w_run_done) begin
                if (r_dir) begin
                    r_out_block <= r_cbc ? (core_o ^ r_chain) : core_o;
                    if (r_cbc) begin
                        r_chain <= r_saved_in;
                    end
                end else begin
                    r_out_block <= core_o;
                    if (r_cbc) begin
                        r_chain <= core_o;
                    end
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_block  = r_out_block;
    assign error      = r_error;
    assign core_Reset = ~Reset_n;
    assign core_Start = w_start;
    assign core_EnDe  = r_dir;
    assign core_block = r_core_block;
    assign core_key   = r_core_key;

endmodule

// File: doc/twofish_mode_ctrl.md
# twofish_mode_ctrl

Block-mode sequencer that sits in front of the Twofish round datapath. It accepts 128-bit blocks over a valid/ready stream and applies ECB or CBC chaining in either direction. It drives the core's Start/EnDe/block/key inputs, tracks the core's busy flag, and returns results over a second valid/ready stream. It owns the CBC chaining register and holds every core input stable for the whole core operation.

## Interface
Parameters:
- BUSY_TIMEOUT, 4: max cycles to wait for core busy to rise after Start before flagging an error.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset_n  in  1  synchronous, active-low reset.
- key  in  128  cipher key; sampled on every in-handshake.
- iv  in  128  CBC initial vector.
- iv_load  in  1  when high in IDLE, loads iv into the chain register.
- in_valid / in_ready  in / out  1 / 1  input block handshake.
- in_block  in  128  plaintext (encrypt) or ciphertext (decrypt).
- in_dir  in  1  0 = encrypt, 1 = decrypt; same encoding as core EnDe.
- in_cbc  in  1  0 = ECB, 1 = CBC.
- out_valid / out_ready  out / in  1 / 1  output block handshake.
- out_block  out  128  result block.
- error  out  1  sticky; core failed to go busy within BUSY_TIMEOUT.
- core_Reset  out  1  active-high reset to the core; equals ~Reset_n.
- core_Start, core_EnDe  out  1  core controls.
- core_block, core_key  out  128  core data inputs, registered.
- core_o  in  128  core result.
- core_busy  in  1  core busy flag.

## Operation
- FSM states: IDLE, LOAD, WAIT_BUSY, RUN, OUT, ERR.
- IDLE: in_ready=1. iv_load has priority over a same-cycle in_valid: the IV loads and in_ready is forced 0 that cycle.
- On in-handshake, register: dir, cbc, key, saved_in=in_block. core_block gets in_block ^ chain if (cbc & ~dir), otherwise in_block. Next state is LOAD.
- LOAD: core_Start=1 for exactly one cycle. Next state is WAIT_BUSY.
- WAIT_BUSY: on core_busy=1, go to RUN. If BUSY_TIMEOUT cycles elapse without busy, set error and go to ERR.
- RUN: wait for core_busy=0. On that cycle, capture out_block and go to OUT.
  - Encrypt: out_block = core_o. If cbc, chain <= core_o.
  - Decrypt: out_block = core_o ^ chain when cbc, else core_o. If cbc, chain <= saved_in.
- OUT: out_valid=1, with out_block held until out_ready. On handshake, go to IDLE.
- ERR: in_ready=0 and out_valid=0. Only Reset_n exits ERR.
- ECB blocks never read or modify chain. ECB and CBC blocks may interleave; chain persists across ECB blocks.
- core_EnDe, core_block and core_key are stable from LOAD through RUN inclusive, because the core reads EnDe combinationally every cycle.
- All XORs are a full-width 128-bit bitwise XOR on the bus as presented. The core performs its own byte-order conversion.

## Timing
- Reset (Reset_n=0 at a posedge):
  - FSM returns to IDLE; chain=0, error=0.
  - out_valid=0, core_Start=0, core_EnDe=0; core_block and core_key =0.
  - in_ready=1 on the first cycle after release.
  - core_Reset=1 while Reset_n=0, which aborts any in-flight core operation.
  - Reset mid-block discards the block; no out_valid is produced.
- Handshake at edge T: LOAD during T+1, with core_Start high. The core raises busy at edge T+2, so WAIT_BUSY lasts one cycle.
- out_valid rises the cycle after the RUN cycle in which core_busy is sampled low. Total latency is core_latency + 3 cycles.
- Throughput: one block in flight. in_ready stays 0 from the handshake until the output handshake completes.
- out_ready=0 stalls in OUT indefinitely with out_block held. It has no effect on chain.
- core_Start is never asserted while core_busy=1.
- in_valid while not in IDLE is ignored; the source must hold its data until in_ready.

## Test plan
- ECB encrypt: key=0, in_block=0 -> out_block=9F589F5CF6122C32B6BFEC2F2AE8C35A; core_Start high exactly one cycle.
- ECB decrypt: key=0, in_block=9F589F5CF6122C32B6BFEC2F2AE8C35A, dir=1 -> out_block=0; chain unchanged.
- CBC encrypt, two blocks: iv=0 loaded, key=0, blocks 0 then 0.
  - Block 1 -> 9F58…C35A.
  - Block 2 core_block = 9F58…C35A; output equals the model's ECB encryption of that value.
- CBC round trip: encrypt 3 random blocks with IV X, reload IV X, decrypt the 3 ciphertexts -> original plaintexts, bit-exact.
- Backpressure and reset:
  - Hold out_ready=0 for 50 cycles -> out_block stable, in_ready=0.
  - Assert Reset_n=0 during RUN -> out_valid never rises; in_ready=1 after release; chain=0.
- Timeout: core model never raises busy -> error=1 after BUSY_TIMEOUT cycles; in_ready stays 0 until reset.
